// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receiver/transmitter
//                family: parity selection, receiver FSM states and the baud
//                divider calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Clocks per oversample tick; never below 1 so the divider stays valid.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        int unsigned d;
        d = clk_freq / (baud * ovs);
        return (d == 0) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_rx_gen_if
//  Description : Received-frame handshake bundle: held payload with error
//                flags, valid/ready acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_gen_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_perr;
    logic                 rx_ferr;

    modport master (output rx_data, output rx_valid, output rx_perr,
                    output rx_ferr, input rx_ready);
    modport slave  (input rx_data, input rx_valid, input rx_perr,
                    input rx_ferr, output rx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Free-running divider emitting a one-clock oversample tick
//                every DIV clocks. Shared by the UART receiver and transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int unsigned DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      tick
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..DIV-1 and wrap; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)                r_cnt <= '0;
        else if (r_cnt == c_last) r_cnt <= '0;
        else                     r_cnt <= r_cnt + 1'b1;
    end

    assign tick = (r_cnt == c_last);
endmodule
`default_nettype wire

// File: rtl/uart_rx_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_rx_gen
//  Description : Parametrised UART receiver with 3-sample majority voting,
//                optional parity, 1/2 stop bits, held valid/ready output,
//                overrun and break detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned OVS       = 16,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       rx,
    uart_rx_gen_if.master   rx_if,
    output logic            overrun,
    output logic            break_det,
    output logic            rx_busy
);
    localparam int unsigned c_div  = baud_div(CLK_FREQ, BAUD, OVS);
    localparam int unsigned TCW    = $clog2(OVS);
    localparam int unsigned BCW    = $clog2(DATA_BITS);
    localparam logic [1:0]  c_par  = 2'(PARITY);
    localparam bit          c_has_par = (PARITY != 0);

    localparam logic [TCW-1:0] c_tk_s0   = TCW'(OVS/2 - 1);
    localparam logic [TCW-1:0] c_tk_s1   = TCW'(OVS/2);
    localparam logic [TCW-1:0] c_tk_mid  = TCW'(OVS/2 + 1);
    localparam logic [TCW-1:0] c_tk_last = TCW'(OVS - 1);
    localparam logic [BCW-1:0] c_bit_last  = BCW'(DATA_BITS - 1);
    localparam logic           c_stop_last = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_st_idle   = ST_IDLE;
    localparam logic [2:0] c_st_start  = ST_START;
    localparam logic [2:0] c_st_data   = ST_DATA;
    localparam logic [2:0] c_st_parity = ST_PARITY;
    localparam logic [2:0] c_st_stop   = ST_STOP;

    logic                 r_sync1, r_sync2;
    logic                 w_rxs, w_tick, w_maj, w_calc_par, w_ferr_now, w_brk;
    logic [2:0]           r_state;
    logic [TCW-1:0]       r_tick_cnt;
    logic [BCW-1:0]       r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_samp0, r_samp1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit, r_perr_int, r_ferr_int, r_wait_high;
    logic                 r_done, r_frm_perr, r_frm_ferr, r_frm_brk;
    logic [DATA_BITS-1:0] r_frm_data;

    uart_baud_gen #(.DIV(c_div)) u_baud (.clk(clk), .rst(rst), .tick(w_tick));

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs      = r_sync2;
    // Third sample is the live value on the evaluating tick.
    assign w_maj      = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);
    assign w_calc_par = (c_par == PAR_ODD) ? ~^r_shift : ^r_shift;
    assign w_ferr_now = r_ferr_int | ~w_maj;
    assign w_brk      = (r_shift == '0) && (!c_has_par || !r_par_bit) && w_ferr_now;
    assign rx_busy    = (r_state != c_st_idle);

    // Frame FSM; every decision is qualified by the oversample tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_samp0     <= 1'b1;
            r_samp1     <= 1'b1;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_perr_int  <= 1'b0;
            r_ferr_int  <= 1'b0;
            r_wait_high <= 1'b0;
            r_done      <= 1'b0;
            r_frm_data  <= '0;
            r_frm_perr  <= 1'b0;
            r_frm_ferr  <= 1'b0;
            r_frm_brk   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A break holds off new starts until the line has returned high.
            if (w_rxs) r_wait_high <= 1'b0;
            if (w_tick) begin
                if (r_tick_cnt == c_tk_s0) r_samp0 <= w_rxs;
                if (r_tick_cnt == c_tk_s1) r_samp1 <= w_rxs;
                r_tick_cnt <= (r_tick_cnt == c_tk_last) ? '0 : r_tick_cnt + 1'b1;
                case (r_state)
                    c_st_idle: begin
                        r_tick_cnt <= '0;
                        if (!w_rxs && !r_wait_high) begin
                            r_state    <= c_st_start;
                            r_shift    <= '0;
                            r_par_bit  <= 1'b0;
                            r_perr_int <= 1'b0;
                            r_ferr_int <= 1'b0;
                        end
                    end
                    c_st_start: begin
                        if (r_tick_cnt == c_tk_mid && w_maj) begin
                            r_state    <= c_st_idle;
                            r_tick_cnt <= '0;
                        end else if (r_tick_cnt == c_tk_last) begin
                            r_state   <= c_st_data;
                            r_bit_cnt <= '0;
                        end
                    end
                    c_st_data: begin
                        if (r_tick_cnt == c_tk_mid) r_shift[r_bit_cnt] <= w_maj;
                        if (r_tick_cnt == c_tk_last) begin
                            if (r_bit_cnt == c_bit_last) begin
                                r_state    <= c_has_par ? c_st_parity : c_st_stop;
                                r_stop_cnt <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    c_st_parity: begin
                        if (r_tick_cnt == c_tk_mid) begin
                            r_par_bit  <= w_maj;
                            r_perr_int <= (w_maj != w_calc_par);
                        end
                        if (r_tick_cnt == c_tk_last) begin
                            r_state    <= c_st_stop;
                            r_stop_cnt <= 1'b0;
                        end
                    end
                    c_st_stop: begin
                        if (r_tick_cnt == c_tk_mid) begin
                            if (!w_maj) r_ferr_int <= 1'b1;
                            // Finish at mid final stop so the next start edge is not missed.
                            if (r_stop_cnt == c_stop_last) begin
                                r_state     <= c_st_idle;
                                r_tick_cnt  <= '0;
                                r_done      <= 1'b1;
                                r_frm_data  <= r_shift;
                                r_frm_perr  <= r_perr_int;
                                r_frm_ferr  <= w_ferr_now;
                                r_frm_brk   <= w_brk;
                                r_wait_high <= w_brk;
                            end
                        end else if (r_tick_cnt == c_tk_last) begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= c_st_idle;
                        r_tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Output holding register with valid/ready handshake and overrun drop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
            rx_if.rx_perr  <= 1'b0;
            rx_if.rx_ferr  <= 1'b0;
            overrun        <= 1'b0;
            break_det      <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            if (r_done) begin
                break_det <= r_frm_brk;
                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                    rx_if.rx_data  <= r_frm_data;
                    rx_if.rx_perr  <= r_frm_perr;
                    rx_if.rx_ferr  <= r_frm_ferr;
                    rx_if.rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
